// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit controller.
// Holds the FSM state encoding, RISC-V funct3 width codes and lane/fault decode.
package lsu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Illegal width code, unsigned store, or address not aligned to the access size.
  function automatic logic is_fault(input logic we, input logic [2:0] f3, input logic [1:0] lane);
    logic f;
    f = 1'b0;
    case (f3)
      F3_B:    f = 1'b0;
      F3_BU:   f = we;
      F3_H:    f = lane[0];
      F3_HU:   f = we | lane[0];
      F3_W:    f = (lane != 2'b00);
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [BE_W-1:0] lane_be(input logic [2:0] f3, input logic [1:0] lane);
    logic [BE_W-1:0] be;
    case (f3)
      F3_B, F3_BU: be = 4'b0001 << lane;
      F3_H, F3_HU: be = 4'b0011 << lane;
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [DATA_W-1:0] be_mask(input logic [BE_W-1:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Load-data alignment: moves the addressed lane down to bit 0 and
// sign- or zero-extends it according to the access width code.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] load_data_c
);

  logic [DATA_W-1:0] shifted;

  always_comb begin
    shifted     = rdata >> {lane, 3'b000};
    load_data_c = '0;
    case (funct3)
      F3_B:    load_data_c = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data_c = {24'h0, shifted[7:0]};
      F3_H:    load_data_c = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data_c = {16'h0, shifted[15:0]};
      F3_W:    load_data_c = rdata;
      default: load_data_c = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store controller between the pipeline and a word-wide
// memory port; all outputs come from flops so no req_* path reaches mem_*.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_fault,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BE_W-1:0]   mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        lane_q, lane_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
  logic              rsp_fault_q, rsp_fault_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [1:0]        req_lane;
  logic              req_fault_c;
  logic [BE_W-1:0]   req_be_c;
  logic [DATA_W-1:0] load_data_c;

  assign req_lane    = req_addr[1:0];
  assign req_fault_c = is_fault(req_we, req_funct3, req_lane);
  assign req_be_c    = lane_be(req_funct3, req_lane);

  lsu_align u_align (
    .funct3      (funct3_q),
    .lane        (lane_q),
    .rdata       (mem_rdata),
    .load_data_c (load_data_c)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    lane_d      = lane_q;
    tag_d       = tag_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_fault_d = rsp_fault_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d        = req_we;
          funct3_d    = req_funct3;
          lane_d      = req_lane;
          tag_d       = req_tag;
          req_ready_d = 1'b0;
          if (req_fault_c) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
            rsp_tag_d   = req_tag;
            rsp_rdata_d = '0;
          end else begin
            state_d     = ISSUE;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_be_d    = req_we ? req_be_c : '0;
            mem_wdata_d = req_we ? ((req_wdata << {req_lane, 3'b000}) & be_mask(req_be_c)) : '0;
          end
        end
      end
      ISSUE: begin
        if (mem_gnt) begin
          state_d     = WAIT;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_be_d    = '0;
          mem_wdata_d = '0;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_fault_d = 1'b0;
          rsp_tag_d   = tag_q;
          rsp_rdata_d = we_q ? '0 : load_data_c;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_fault_d = 1'b0;
          rsp_tag_d   = '0;
          rsp_rdata_d = '0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      lane_q      <= '0;
      tag_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_tag_q   <= '0;
      rsp_fault_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      lane_q      <= lane_d;
      tag_q       <= tag_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_fault_q <= rsp_fault_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_fault = rsp_fault_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of req_addr and mem_addr.
REQ-002 SHALL have parameter TAG_W, default 5, width of destination-register tag.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid / req_ready  in / out  1  pipeline request handshake.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_funct3  in  3  RISC-V width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 req_addr  in  ADDR_W  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 req_tag  in  TAG_W  destination tag, returned unchanged.
REQ-012 rsp_valid / rsp_ready  out / in  1  response handshake.
REQ-013 rsp_rdata  out  32  lane-shifted, extended load data; 0 for stores and faults.
REQ-014 rsp_tag  out  TAG_W  latched req_tag.
REQ-015 rsp_fault  out  1  misaligned address or illegal funct3.
REQ-016 mem_req / mem_gnt  out / in  1  memory request handshake.
REQ-017 mem_we  out 1; mem_addr  out ADDR_W, word-aligned ([1:0]=00); mem_be  out 4; mem_wdata  out 32.
REQ-018 mem_rvalid  in 1; mem_rdata  in 32  memory completion, one pulse per granted request, for loads and stores.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT, RESP; exactly one transaction outstanding.
REQ-020 IDLE: req_ready=1, all other outputs 0; req_valid latches we/funct3/addr/wdata/tag.
REQ-021 From IDLE on accept: fault -> RESP with rsp_fault=1 and no memory access; otherwise -> ISSUE.
REQ-022 Fault: funct3 in {011,110,111}; store funct3 not in {000,001,010}; H/HU with addr[0]=1; W with addr[1:0]!=00.
REQ-023 ISSUE: mem_req=1 with stable mem_* until the cycle mem_gnt=1, then -> WAIT.
REQ-024 WAIT: on mem_rvalid capture result -> RESP; otherwise hold.
REQ-025 RESP: rsp_valid=1, rsp_* stable until rsp_ready=1, then -> IDLE; req_ready=0 in RESP.
REQ-026 Lane: l = addr[1:0]; mem_be = 0001<<l (B), 0011<<l (H), 1111 (W); mem_wdata = req_wdata shifted left 8*l, unused lanes 0.
REQ-027 Load: mem_rdata shifted right 8*l, then sign-extend (B, H) or zero-extend (BU, HU); W passes unchanged.
REQ-028 Minimum latency: accept edge N, gnt in ISSUE at N+1, rvalid at N+2, rsp_valid high from N+3; fault response at N+1.
REQ-029 mem_gnt or mem_rvalid outside ISSUE/WAIT respectively SHALL be ignored.
REQ-030 mem_rvalid in same cycle as mem_gnt SHALL be ignored; completion is taken only in WAIT.
REQ-031 All outputs are registered or decoded from state and latched registers only; no combinational path from req_* to mem_*.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, clear all latched registers, and drive req_ready=1 and all other outputs 0.
REQ-033 Reset mid-transaction abandons it; a late mem_rvalid after reset SHALL be ignored per REQ-029.

Structure
REQ-034 Package lsu_pkg SHALL hold the state enum and funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
REQ-035 One combinational sub-module lsu_align SHALL perform lane shift plus sign/zero extension.

Verification
REQ-036 LB addr 0x1003, mem_rdata 0x80FF_FF00 -> rsp_rdata 0xFFFF_FF80, mem_addr 0x1000, mem_be 0000, rsp_valid at N+3.
REQ-037 SH addr 0x2002, wdata 0x0000_BEEF -> mem_be 1100, mem_wdata 0xBEEF_0000, mem_we 1, rsp_rdata 0, rsp_fault 0.
REQ-038 LW addr 0x3001 -> rsp_fault 1 at N+1, mem_req never asserted; funct3 011 gives same.
REQ-039 LHU addr 0x4002, gnt delayed 3 cycles, rvalid 2 more, rsp_ready held low 2 -> mem_* stable, rsp_rdata 0x0000_8001 for mem_rdata 0x8001_1234, stable until accepted.
REQ-040 rst_n low in WAIT, then rvalid pulse after release -> IDLE, req_ready 1, rsp_valid stays 0.
